multicycle_control: RTL and testbench

//  Multi-cycle control FSM for the reduced RISC-V core; replaces the single-cycle flag decoder.

---
 rtl/control_pkg.sv | 40 ++++
 rtl/instr_decoder.sv | 100 ++++++++++
 rtl/multicycle_control.sv | 148 ++++++++++++++
 tb/tb_multicycle_control.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/control_pkg.sv
// Shared types and encodings for the multi-cycle control unit.
//   state_t  : control FSM states
//   iclass_t : instruction class produced by the decoder
//   opcode, ALU operation and immediate-format encodings
package control_pkg;

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEM       = 3'd3,
    WRITEBACK = 3'd4,
    TRAP      = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    CL_NONE   = 3'd0,
    CL_ALU    = 3'd1,
    CL_BRANCH = 3'd2,
    CL_LOAD   = 3'd3,
    CL_STORE  = 3'd4
  } iclass_t;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;

endpackage

// File: rtl/instr_decoder.sv
// Combinational instruction classifier.
//   ir        : latched instruction word
//   iclass    : ALU / BRANCH / LOAD / STORE (CL_NONE when illegal)
//   legal     : encoding is one the core supports
//   alu_ctrl  : ALU operation for the EXECUTE..WRITEBACK window
//   alu_src   : 0 rs2, 1 immediate
//   imm_src   : immediate format (I/S/B)
//   is_bne    : branch is BNE (0 means BEQ)
module instr_decoder
  import control_pkg::*;
#(
  parameter bit EN_LOADSTORE = 1'b1
) (
  input  logic [31:0] ir,
  output iclass_t     iclass,
  output logic        legal,
  output logic [2:0]  alu_ctrl,
  output logic        alu_src,
  output logic [1:0]  imm_src,
  output logic        is_bne
);

  logic [6:0] opcode;
  logic [2:0] fn3;
  logic [6:0] fn7;

  assign opcode = ir[6:0];
  assign fn3    = ir[14:12];
  assign fn7    = ir[31:25];

  // Register and immediate fields belong to the datapath, not to control.
  logic unused_fields;
  assign unused_fields = ^{ir[24:15], ir[11:7]};

  always_comb begin
    iclass   = CL_NONE;
    legal    = 1'b0;
    alu_ctrl = ALU_ADD;
    alu_src  = 1'b0;
    imm_src  = IMM_I;
    is_bne   = 1'b0;
    case (opcode)
      OP_IMM: begin
        alu_src = 1'b1;
        imm_src = IMM_I;
        case (fn3)
          3'b000:  begin legal = 1'b1; alu_ctrl = ALU_ADD; end
          3'b111:  begin legal = 1'b1; alu_ctrl = ALU_AND; end
          3'b110:  begin legal = 1'b1; alu_ctrl = ALU_OR;  end
          3'b010:  begin legal = 1'b1; alu_ctrl = ALU_SLT; end
          default: legal = 1'b0;
        endcase
        if (legal) iclass = CL_ALU;
      end
      OP: begin
        case (fn3)
          3'b000: begin
            if (fn7 == 7'b0000000) begin
              legal = 1'b1; alu_ctrl = ALU_ADD;
            end else if (fn7 == 7'b0100000) begin
              legal = 1'b1; alu_ctrl = ALU_SUB;
            end
          end
          3'b111:  if (fn7 == 7'b0000000) begin legal = 1'b1; alu_ctrl = ALU_AND; end
          3'b110:  if (fn7 == 7'b0000000) begin legal = 1'b1; alu_ctrl = ALU_OR;  end
          3'b010:  if (fn7 == 7'b0000000) begin legal = 1'b1; alu_ctrl = ALU_SLT; end
          default: legal = 1'b0;
        endcase
        if (legal) iclass = CL_ALU;
      end
      BRANCH: begin
        if (fn3 == 3'b000 || fn3 == 3'b001) begin
          legal    = 1'b1;
          iclass   = CL_BRANCH;
          alu_ctrl = ALU_SUB;
          imm_src  = IMM_B;
          is_bne   = fn3[0];
        end
      end
      LOAD: begin
        if (EN_LOADSTORE && fn3 == 3'b010) begin
          legal   = 1'b1;
          iclass  = CL_LOAD;
          alu_src = 1'b1;
          imm_src = IMM_I;
        end
      end
      STORE: begin
        if (EN_LOADSTORE && fn3 == 3'b010) begin
          legal   = 1'b1;
          iclass  = CL_STORE;
          alu_src = 1'b1;
          imm_src = IMM_S;
        end
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle control FSM for the reduced RISC-V core.
// Sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK, traps illegal encodings,
// counts retired instructions.
//   clk, rst              : clock, asynchronous active-high reset
//   instr, imem_ready     : instruction word, accepted in FETCH when imem_ready=1
//   dmem_ready            : completes the data access in MEM
//   EQ                    : datapath comparator (1 when rs1 != rs2)
//   PCWrite/PCsrc         : PC update pulse and source (0 PC+4, 1 PC+imm)
//   IRWrite, RegWrite     : instruction-register / register-file write pulses
//   ALUctrl/ALUsrc/ImmSrc : datapath selects, held EXECUTE..MEM/WRITEBACK
//   MemRead/MemWrite      : data memory request, level until dmem_ready
//   ResultSrc             : 1 selects load data for write-back
//   illegal               : sticky trap flag
//   retired               : completed-instruction counter (wraps)
// Handshake: each ready input is a completion strobe, only looked at in the
// state that waits for it; a request is never withdrawn before its ready
// except by reset.
module multicycle_control
  import control_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int RETIRE_WIDTH  = 32,
  parameter bit EN_LOADSTORE  = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDRESS_WIDTH-1:0] instr,
  input  logic                     imem_ready,
  input  logic                     dmem_ready,
  input  logic                     EQ,
  output logic                     PCWrite,
  output logic                     PCsrc,
  output logic                     IRWrite,
  output logic                     RegWrite,
  output logic [2:0]               ALUctrl,
  output logic                     ALUsrc,
  output logic [1:0]               ImmSrc,
  output logic                     MemRead,
  output logic                     MemWrite,
  output logic                     ResultSrc,
  output logic                     illegal,
  output logic [RETIRE_WIDTH-1:0]  retired
);

  state_t      state, state_n;
  logic [31:0] ir;
  logic        retire;

  iclass_t     dec_class;
  logic        dec_legal;
  logic [2:0]  dec_alu;
  logic        dec_src;
  logic [1:0]  dec_imm;
  logic        dec_bne;

  instr_decoder #(.EN_LOADSTORE(EN_LOADSTORE)) u_dec (
    .ir       (ir),
    .iclass   (dec_class),
    .legal    (dec_legal),
    .alu_ctrl (dec_alu),
    .alu_src  (dec_src),
    .imm_src  (dec_imm),
    .is_bne   (dec_bne)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= FETCH;
      ir      <= '0;
      illegal <= 1'b0;
      retired <= '0;
    end else begin
      state <= state_n;
      if (IRWrite) ir <= instr[31:0];
      if (state == DECODE && !dec_legal) illegal <= 1'b1;
      if (retire) retired <= retired + {{(RETIRE_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  always_comb begin
    state_n   = state;
    retire    = 1'b0;
    PCWrite   = 1'b0;
    PCsrc     = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    ALUctrl   = 3'b000;
    ALUsrc    = 1'b0;
    ImmSrc    = 2'b00;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    ResultSrc = 1'b0;
    // Outputs are forced quiet while reset is asserted so nothing
    // (e.g. IRWrite with imem_ready high) leaks during reset.
    if (!rst) begin
      if (state == EXECUTE || state == MEM || state == WRITEBACK) begin
        ALUctrl   = dec_alu;
        ALUsrc    = dec_src;
        ImmSrc    = dec_imm;
        ResultSrc = (dec_class == CL_LOAD);
      end
      case (state)
        FETCH: begin
          if (imem_ready) begin
            IRWrite = 1'b1;
            state_n = DECODE;
          end
        end
        DECODE: state_n = dec_legal ? EXECUTE : TRAP;
        EXECUTE: begin
          case (dec_class)
            CL_BRANCH: begin
              PCWrite = 1'b1;
              // EQ is high when the operands differ.
              PCsrc   = dec_bne ? EQ : ~EQ;
              retire  = 1'b1;
              state_n = FETCH;
            end
            CL_LOAD, CL_STORE: state_n = MEM;
            default:           state_n = WRITEBACK;
          endcase
        end
        MEM: begin
          MemRead  = (dec_class == CL_LOAD);
          MemWrite = (dec_class == CL_STORE);
          if (dmem_ready) begin
            if (dec_class == CL_LOAD) begin
              state_n = WRITEBACK;
            end else begin
              PCWrite = 1'b1;
              retire  = 1'b1;
              state_n = FETCH;
            end
          end
        end
        WRITEBACK: begin
          RegWrite = 1'b1;
          PCWrite  = 1'b1;
          retire   = 1'b1;
          state_n  = FETCH;
        end
        TRAP:    state_n = TRAP;
        default: state_n = TRAP;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-instruction cycle schedules built from a
// mask/match instruction table, played cycle by cycle against the DUT.
module tb_multicycle_control;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic [31:0] instr = '0;
  logic        imem_ready = 1'b0, dmem_ready = 1'b0, EQ = 1'b0;
  logic        PCWrite, PCsrc, IRWrite, RegWrite, ALUsrc, MemRead, MemWrite, ResultSrc, illegal;
  logic [2:0]  ALUctrl;
  logic [1:0]  ImmSrc;
  logic [31:0] retired;

  multicycle_control dut (
    .clk(clk), .rst(rst), .instr(instr), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .EQ(EQ), .PCWrite(PCWrite), .PCsrc(PCsrc), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .ALUctrl(ALUctrl), .ALUsrc(ALUsrc), .ImmSrc(ImmSrc), .MemRead(MemRead),
    .MemWrite(MemWrite), .ResultSrc(ResultSrc), .illegal(illegal), .retired(retired)
  );

  // Narrow counter, load/store disabled
  logic        s_rst = 1'b1;
  logic [31:0] s_instr = '0;
  logic        s_imem_ready = 1'b1, s_dmem_ready = 1'b1, s_eq = 1'b0;
  logic        s_PCWrite, s_PCsrc, s_IRWrite, s_RegWrite, s_ALUsrc, s_MemRead, s_MemWrite;
  logic        s_ResultSrc, s_illegal;
  logic [2:0]  s_ALUctrl;
  logic [1:0]  s_ImmSrc;
  logic [3:0]  s_retired;

  multicycle_control #(.RETIRE_WIDTH(4), .EN_LOADSTORE(1'b0)) dut_small (
    .clk(clk), .rst(s_rst), .instr(s_instr), .imem_ready(s_imem_ready),
    .dmem_ready(s_dmem_ready), .EQ(s_eq), .PCWrite(s_PCWrite), .PCsrc(s_PCsrc),
    .IRWrite(s_IRWrite), .RegWrite(s_RegWrite), .ALUctrl(s_ALUctrl), .ALUsrc(s_ALUsrc),
    .ImmSrc(s_ImmSrc), .MemRead(s_MemRead), .MemWrite(s_MemWrite),
    .ResultSrc(s_ResultSrc), .illegal(s_illegal), .retired(s_retired)
  );

  logic [14:0] act;
  assign act = {PCWrite, PCsrc, IRWrite, RegWrite, ALUctrl, ALUsrc, ImmSrc,
                MemRead, MemWrite, ResultSrc};

  // ---------------- reference model ----------------
  // kind: 0 ALU, 1 branch, 2 load, 3 store
  string       tbl_name [13] = '{"addi","andi","ori","slti","add","sub","and","or","slt",
                                 "beq","bne","lw","sw"};
  logic [31:0] tbl_mask [13] = '{32'h707F, 32'h707F, 32'h707F, 32'h707F,
                                 32'hFE00707F, 32'hFE00707F, 32'hFE00707F, 32'hFE00707F,
                                 32'hFE00707F, 32'h707F, 32'h707F, 32'h707F, 32'h707F};
  logic [31:0] tbl_match[13] = '{32'h00000013, 32'h00007013, 32'h00006013, 32'h00002013,
                                 32'h00000033, 32'h40000033, 32'h00007033, 32'h00006033,
                                 32'h00002033, 32'h00000063, 32'h00001063, 32'h00002003,
                                 32'h00002023};
  int          tbl_kind [13] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2, 3};
  logic [2:0]  tbl_alu  [13] = '{3'd0, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4,
                                 3'd1, 3'd1, 3'd0, 3'd0};
  logic        tbl_src  [13] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                 1'b0, 1'b0, 1'b1, 1'b1};
  logic [1:0]  tbl_imm  [13] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0,
                                 2'd2, 2'd2, 2'd0, 2'd1};

  function automatic int ref_find(input logic [31:0] w, input bit en_ls);
    for (int i = 0; i < 13; i++)
      if ((w & tbl_mask[i]) == tbl_match[i] && (tbl_kind[i] < 2 || en_ls)) return i;
    return -1;
  endfunction

  function automatic logic [14:0] mk(input bit pcw, input bit pcs, input bit irw, input bit rw,
                                     input logic [2:0] alu, input bit src, input logic [1:0] imm,
                                     input bit mr, input bit mw, input bit rs);
    return {pcw, pcs, irw, rw, alu, src, imm, mr, mw, rs};
  endfunction

  // ---------------- scoreboard ----------------
  logic [14:0] exp_q[$];
  logic        drv_imem_q[$];
  logic        drv_dmem_q[$];
  logic [31:0] model_retired = 0;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input bit im, input bit dm, input logic [14:0] v);
    drv_imem_q.push_back(im);
    drv_dmem_q.push_back(dm);
    exp_q.push_back(v);
  endtask

  // ---------------- driver tasks ----------------
  task automatic play(input string name, input logic [31:0] w, input bit eq);
    int c = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      imem_ready = drv_imem_q.pop_front();
      dmem_ready = drv_dmem_q.pop_front();
      instr      = w;
      EQ         = eq;
      #1;
      c++;
      check($sformatf("%s_c%0d", name, c), {17'd0, act}, {17'd0, exp_q.pop_front()});
    end
  endtask

  // Fetch (with di wait cycles) and decode, common to every instruction.
  task automatic push_front_end(input int di);
    for (int i = 0; i < di; i++) push(1'b0, 1'($urandom_range(1, 0)), '0);
    push(1'b1, 1'($urandom_range(1, 0)), mk(0, 0, 1, 0, 3'd0, 0, 2'd0, 0, 0, 0));
    push(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), '0);
  endtask

  task automatic run_instr(input logic [31:0] w, input int di, input int dd, input bit eq);
    int k = ref_find(w, 1'b1);
    logic [2:0] a;
    bit s, ld, st;
    logic [1:0] im;
    if (k < 0) begin
      check("model_legal", 32'd0, 32'd1);
      return;
    end
    a = tbl_alu[k]; s = tbl_src[k]; im = tbl_imm[k];
    ld = (tbl_kind[k] == 2); st = (tbl_kind[k] == 3);
    push_front_end(di);
    if (tbl_kind[k] == 1)
      push(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
           mk(1, (k == 10) ? eq : !eq, 0, 0, a, s, im, 0, 0, 0));
    else
      push(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), mk(0, 0, 0, 0, a, s, im, 0, 0, ld));
    if (ld || st) begin
      for (int i = 0; i < dd; i++)
        push(1'($urandom_range(1, 0)), 1'b0, mk(0, 0, 0, 0, a, s, im, ld, st, ld));
      push(1'($urandom_range(1, 0)), 1'b1, mk(st, 0, 0, 0, a, s, im, ld, st, ld));
    end
    if (tbl_kind[k] == 0 || ld)
      push(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), mk(1, 0, 0, 1, a, s, im, 0, 0, ld));
    play(tbl_name[k], w, eq);
    @(posedge clk); #1;
    model_retired++;
    check($sformatf("%s_retired", tbl_name[k]), retired, model_retired);
    check($sformatf("%s_illegal", tbl_name[k]), {31'd0, illegal}, 32'd0);
  endtask

  task automatic run_trap(input string name, input logic [31:0] w);
    push_front_end(0);
    play(name, w, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      imem_ready = 1'($urandom_range(1, 0));
      dmem_ready = 1'($urandom_range(1, 0));
      EQ         = 1'($urandom_range(1, 0));
      #1;
      check($sformatf("%s_trap_strobes", name), {17'd0, act}, 32'd0);
      check($sformatf("%s_trap_illegal", name), {31'd0, illegal}, 32'd1);
      check($sformatf("%s_trap_retired", name), retired, model_retired);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b1;
    #1;
    model_retired = 0;
    check("reset_strobes", {17'd0, act}, 32'd0);
    check("reset_illegal", {31'd0, illegal}, 32'd0);
    check("reset_retired", retired, model_retired);
    @(negedge clk);
    rst = 1'b0; imem_ready = 1'b0;
  endtask

  function automatic logic [31:0] rand_legal();
    int k = $urandom_range(12, 0);
    return ($urandom() & ~tbl_mask[k]) | tbl_match[k];
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] w;
    logic [31:0] bad [3];
    do_reset();

    // Directed cases
    run_instr(32'h00500093, 0, 0, 1'b0);   // addi x1,x0,5
    run_instr(32'h00209463, 0, 0, 1'b1);   // bne taken
    run_instr(32'h00209463, 0, 0, 1'b0);   // bne not taken
    run_instr(32'h00208463, 0, 0, 1'b1);   // beq not taken
    run_instr(32'h00208463, 0, 0, 1'b0);   // beq taken
    run_instr(32'h0000a183, 2, 3, 1'b0);   // lw, dmem_ready low 3 cycles
    run_instr(32'h0030a023, 0, 2, 1'b0);   // sw
    run_instr(32'h40208033, 1, 0, 1'b0);   // sub

    // Random legal stream
    for (int n = 0; n < 60; n++)
      run_instr(rand_legal(), $urandom_range(3, 0), $urandom_range(3, 0), 1'($urandom_range(1, 0)));

    // Reset in the middle of a load's memory wait
    push_front_end(0);
    push(1'b0, 1'b0, mk(0, 0, 0, 0, 3'd0, 1, 2'd0, 0, 0, 1));
    push(1'b0, 1'b0, mk(0, 0, 0, 0, 3'd0, 1, 2'd0, 1, 0, 1));
    push(1'b0, 1'b0, mk(0, 0, 0, 0, 3'd0, 1, 2'd0, 1, 0, 1));
    play("lw_midmem", 32'h0000a183, 1'b0);
    #1 rst = 1'b1;
    #1;
    model_retired = 0;
    check("midmem_memread", {31'd0, MemRead}, 32'd0);
    check("midmem_retired", retired, model_retired);
    @(negedge clk);
    rst = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
    run_instr(32'h00500093, 0, 0, 1'b0);

    // Illegal encodings
    bad[0] = 32'h0000007F;
    bad[1] = 32'h02000033;
    bad[2] = 32'h0000007F;
    for (int t = 0; t < 100; t++) begin
      w = $urandom();
      if (ref_find(w, 1'b1) < 0) begin bad[2] = w; break; end
    end
    for (int b = 0; b < 3; b++) begin
      do_reset();
      run_instr(rand_legal(), 0, 0, 1'b0);
      run_instr(rand_legal(), 1, 1, 1'b1);
      run_trap($sformatf("illegal%0d", b), bad[b]);
    end
    do_reset();
    run_instr(32'h00500093, 0, 0, 1'b0);

    // Narrow counter wrap, then a store that must trap
    @(negedge clk);
    s_instr = 32'h00500093;
    s_rst   = 1'b0;
    for (int n = 1; n <= 16; n++) begin
      repeat (4) @(negedge clk);
      #1;
      check($sformatf("wrap_retired_%0d", n), {28'd0, s_retired}, n % 16);
    end
    s_instr = 32'h0030a023;
    repeat (3) @(negedge clk);
    #1;
    check("nols_sw_illegal", {31'd0, s_illegal}, 32'd1);
    check("nols_sw_memwrite", {31'd0, s_MemWrite}, 32'd0);
    check("nols_sw_retired", {28'd0, s_retired}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
